// File: rtl/pixel_pair_feeder.sv
// Pairs two independently buffered pixel streams and issues one frame of pixel pairs per start.
// Define PIXEL_PAIR_FEEDER_STALL_COUNT_EN to add the saturating stall_cycles output.
module pixel_pair_feeder #(
    parameter int unsigned PIXEL_DEPTH  = 8,
    parameter int unsigned OPCODE_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned FRAME_PIXELS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIXEL_DEPTH-1:0]  a_data,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [PIXEL_DEPTH-1:0]  b_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [OPCODE_WIDTH-1:0] cfg_opcode,
    input  logic [PIXEL_DEPTH-1:0]  cfg_user,
    input  logic                    cfg_load,
    input  logic                    start,
    output logic [PIXEL_DEPTH-1:0]  pixelA,
    output logic [PIXEL_DEPTH-1:0]  pixelB,
    output logic [PIXEL_DEPTH-1:0]  userInputA,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    issue_valid,
    output logic                    busy,
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
    output logic [15:0]             stall_cycles,
`endif
    output logic                    frame_done
);

    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = ADDR_W + 1;
    localparam int unsigned CNT_W  = $clog2(FRAME_PIXELS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [PIXEL_DEPTH-1:0]  mem_a [FIFO_DEPTH];
    logic [PIXEL_DEPTH-1:0]  mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0]        wa_q, wa_d, ra_q, ra_d, wa_vis_q;
    logic [PTR_W-1:0]        wb_q, wb_d, rb_q, rb_d, wb_vis_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PIXEL_DEPTH-1:0]  pix_a_q, pix_a_d, pix_b_q, pix_b_d;
    logic [PIXEL_DEPTH-1:0]  user_q, user_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic                    issue_q, issue_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
    logic [15:0]             stall_q, stall_d;
`endif

    logic empty_a, empty_b, push_a, push_b, pop;

    function automatic logic ptr_full(input logic [PTR_W-1:0] wr, input logic [PTR_W-1:0] rd);
        return (wr[PTR_W-1] != rd[PTR_W-1]) && (wr[ADDR_W-1:0] == rd[ADDR_W-1:0]);
    endfunction

    // Emptiness uses a one-cycle-delayed write pointer so a fresh push is never popped early.
    assign empty_a = (ra_q == wa_vis_q);
    assign empty_b = (rb_q == wb_vis_q);
    assign push_a  = a_valid && a_rdy_q;
    assign push_b  = b_valid && b_rdy_q;
    assign pop     = (state_q == S_RUN) && !empty_a && !empty_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pix_a_d = pix_a_q;
        pix_b_d = pix_b_q;
        user_d  = user_q;
        op_d    = op_q;
        issue_d = 1'b0;
        wa_d    = wa_q + PTR_W'(push_a);
        wb_d    = wb_q + PTR_W'(push_b);
        ra_d    = ra_q + PTR_W'(pop);
        rb_d    = rb_q + PTR_W'(pop);
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    op_d   = cfg_opcode;
                    user_d = cfg_user;
                end
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
                    stall_d = '0;
`endif
                end
            end
            S_RUN: begin
                if (pop) begin
                    pix_a_d = mem_a[ra_q[ADDR_W-1:0]];
                    pix_b_d = mem_b[rb_q[ADDR_W-1:0]];
                    issue_d = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(FRAME_PIXELS)) begin
                        state_d = S_DONE;
                    end
                end
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
                if ((empty_a != empty_b) && (stall_q != 16'hFFFF)) begin
                    stall_d = stall_q + 16'd1;
                end
`endif
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        a_rdy_d = (state_d == S_RUN) && !ptr_full(wa_d, ra_d);
        b_rdy_d = (state_d == S_RUN) && !ptr_full(wb_d, rb_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wa_q     <= '0;
            ra_q     <= '0;
            wa_vis_q <= '0;
            wb_q     <= '0;
            rb_q     <= '0;
            wb_vis_q <= '0;
            cnt_q    <= '0;
            pix_a_q  <= '0;
            pix_b_q  <= '0;
            user_q   <= '0;
            op_q     <= '0;
            issue_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_rdy_q  <= 1'b0;
            b_rdy_q  <= 1'b0;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            ra_q     <= ra_d;
            wa_vis_q <= wa_q;
            wb_q     <= wb_d;
            rb_q     <= rb_d;
            wb_vis_q <= wb_q;
            cnt_q    <= cnt_d;
            pix_a_q  <= pix_a_d;
            pix_b_q  <= pix_b_d;
            user_q   <= user_d;
            op_q     <= op_d;
            issue_q  <= issue_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            a_rdy_q  <= a_rdy_d;
            b_rdy_q  <= b_rdy_d;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
            stall_q  <= stall_d;
`endif
        end
    end

    // FIFO storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_a) mem_a[wa_q[ADDR_W-1:0]] <= a_data;
        if (push_b) mem_b[wb_q[ADDR_W-1:0]] <= b_data;
    end

    assign a_ready     = a_rdy_q;
    assign b_ready     = b_rdy_q;
    assign pixelA      = pix_a_q;
    assign pixelB      = pix_b_q;
    assign userInputA  = user_q;
    assign opcode      = op_q;
    assign issue_valid = issue_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pixel_pair_feeder.sv
// Directed self-checking bench for pixel_pair_feeder with FRAME_PIXELS=4, FIFO_DEPTH=4.
module tb_pixel_pair_feeder;

    localparam int unsigned PD = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned FD = 4;
    localparam int unsigned FP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [PD-1:0] a_data = '0, b_data = '0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic          a_ready, b_ready;
    logic [OW-1:0] cfg_opcode = '0;
    logic [PD-1:0] cfg_user = '0;
    logic          cfg_load = 1'b0, start = 1'b0;
    logic [PD-1:0] pixelA, pixelB, userInputA;
    logic [OW-1:0] opcode;
    logic          issue_valid, busy, frame_done;
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
    logic [15:0]   stall_cycles;
`endif

    pixel_pair_feeder #(
        .PIXEL_DEPTH (PD),
        .OPCODE_WIDTH(OW),
        .FIFO_DEPTH  (FD),
        .FRAME_PIXELS(FP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .cfg_opcode (cfg_opcode),
        .cfg_user   (cfg_user),
        .cfg_load   (cfg_load),
        .start      (start),
        .pixelA     (pixelA),
        .pixelB     (pixelB),
        .userInputA (userInputA),
        .opcode     (opcode),
        .issue_valid(issue_valid),
        .busy       (busy),
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
        .stall_cycles(stall_cycles),
`endif
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [7:0]  qa[$], qb[$];
    logic [15:0] got[$], exp_q[$];
    int          icyc[$];
    int          gap_a = 0, gap_b = 0, cool_a = 0, cool_b = 0;
    int          first_acc = -1, done_cnt = 0, cfg_bad = 0, a_low = 0;
    logic [OW-1:0] exp_op = '0;
    logic [PD-1:0] exp_user = '0;
    int          occ_a = 0, occ_b = 0, exp_stall = 0;
    logic        last_a = 1'b0, last_b = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
        end
    endtask

    // One clock: observe outputs at the falling edge, then drive sources for the next rising edge.
    task automatic step();
        logic acc_a, acc_b, pop_m, run_c;
        int   va, vb;
        @(negedge clk);
        if (issue_valid) begin
            got.push_back({pixelA, pixelB});
            icyc.push_back(cyc);
        end
        if (frame_done) done_cnt++;
        if (busy && (opcode !== exp_op || userInputA !== exp_user)) cfg_bad++;
        if (busy && !frame_done && !a_ready) a_low++;
        run_c = busy && !frame_done;
        va    = occ_a - int'(last_a);
        vb    = occ_b - int'(last_b);
        pop_m = run_c && (va > 0) && (vb > 0);
        if (run_c && ((va > 0) != (vb > 0)) && exp_stall < 65535) exp_stall++;

        a_valid = (qa.size() > 0) && (cool_a == 0);
        a_data  = a_valid ? qa[0] : 8'h00;
        acc_a   = a_valid && a_ready;
        if (acc_a) begin
            void'(qa.pop_front());
            cool_a = gap_a;
            if (first_acc < 0) first_acc = cyc + 1;
        end else if (cool_a > 0) cool_a--;

        b_valid = (qb.size() > 0) && (cool_b == 0);
        b_data  = b_valid ? qb[0] : 8'h00;
        acc_b   = b_valid && b_ready;
        if (acc_b) begin
            void'(qb.pop_front());
            cool_b = gap_b;
        end else if (cool_b > 0) cool_b--;

        occ_a  = occ_a + int'(acc_a) - int'(pop_m);
        occ_b  = occ_b + int'(acc_b) - int'(pop_m);
        last_a = acc_a;
        last_b = acc_b;
    endtask

    task automatic run_until_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_no_timeout"}, 32'(n < 200), 32'd1);
        step();
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_pairs(input string tag);
        check_eq({tag, "_npairs"}, 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[i])
            check_eq($sformatf("%s_pair%0d", tag, i),
                     (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic begin_frame();
        got.delete();
        icyc.delete();
        done_cnt  = 0;
        cfg_bad   = 0;
        a_low     = 0;
        first_acc = -1;
        exp_stall = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_stall(input string tag);
`ifdef PIXEL_PAIR_FEEDER_STALL_COUNT_EN
        check_eq({tag, "_stall"}, 32'(stall_cycles), 32'(exp_stall));
`else
        check_eq({tag, "_stall_model_idle"}, 32'(occ_a >= 0 && occ_b >= 0), 32'd1);
`endif
    endtask

    initial begin
        int n;
        // Reset state
        #12;
        check_eq("rst_pixels", 32'({pixelA, pixelB, userInputA}), 32'd0);
        check_eq("rst_ctrl", 32'({opcode, issue_valid, busy, frame_done, a_ready, b_ready}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        check_eq("idle_ready", 32'({a_ready, b_ready}), 32'd0);
        check_eq("idle_issue", 32'(issue_valid), 32'd0);

        // Config then basic frame
        cfg_opcode = 4'h3;
        cfg_user   = 8'h10;
        cfg_load   = 1'b1;
        step();
        cfg_load   = 1'b0;
        check_eq("cfg_opcode", 32'(opcode), 32'h3);
        check_eq("cfg_user", 32'(userInputA), 32'h10);
        exp_op   = 4'h3;
        exp_user = 8'h10;
        qa = '{8'h01, 8'h02, 8'h03, 8'h04};
        qb = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
        begin_frame();
        run_until_done("t2");
        exp_q = '{16'h01A0, 16'h02B0, 16'h03C0, 16'h04D0};
        check_pairs("t2");
        check_eq("t2_latency", 32'((icyc.size() > 0 ? icyc[0] : -100) - first_acc), 32'd2);
        check_eq("t2_back_to_back", 32'((icyc.size() == 4) ? icyc[3] - icyc[0] : -1), 32'd3);
        check_eq("t2_cfg_stable", 32'(cfg_bad), 32'd0);
        check_eq("t2_never_full", 32'(a_low), 32'd0);
        check_stall("t2");

        // Skewed streams: A bursts, B trickles one beat every third cycle
        qa = '{8'h11, 8'h12, 8'h13, 8'h14};
        qb = '{8'h21, 8'h22, 8'h23, 8'h24};
        gap_b  = 2;
        cool_b = 3;
        begin_frame();
        run_until_done("t3");
        exp_q = '{16'h1121, 16'h1222, 16'h1323, 16'h1424};
        check_pairs("t3");
        check_eq("t3_a_full_seen", 32'(a_low > 0), 32'd1);
        check_eq("t3_spacing", 32'((icyc.size() == 4) ? icyc[3] - icyc[0] : -1), 32'd9);
        check_stall("t3");
        gap_b  = 0;
        cool_b = 0;

        // cfg_load and start during RUN are ignored
        qa = '{8'h31, 8'h32, 8'h33, 8'h34};
        qb = '{8'h41, 8'h42, 8'h43, 8'h44};
        begin_frame();
        step();
        cfg_opcode = 4'h7;
        cfg_user   = 8'h77;
        cfg_load   = 1'b1;
        start      = 1'b1;
        step();
        cfg_load   = 1'b0;
        start      = 1'b0;
        run_until_done("t4");
        exp_q = '{16'h3141, 16'h3242, 16'h3343, 16'h3444};
        check_pairs("t4");
        check_eq("t4_opcode_kept", 32'(opcode), 32'h3);
        check_eq("t4_cfg_stable", 32'(cfg_bad), 32'd0);
        step();
        step();
        step();
        check_eq("t4_no_restart", 32'({busy, 8'(got.size())}), 32'd4);

        // Leftover A entries carry into the next frame
        qa = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
        qb = '{8'h61, 8'h62, 8'h63, 8'h64};
        begin_frame();
        run_until_done("t5");
        exp_q = '{16'h5161, 16'h5262, 16'h5363, 16'h5464};
        check_pairs("t5");
        check_eq("t5_all_a_accepted", 32'(qa.size()), 32'd0);
        qa = '{8'h57, 8'h58};
        qb = '{8'h71, 8'h72, 8'h73, 8'h74};
        begin_frame();
        run_until_done("t5b");
        exp_q = '{16'h5571, 16'h5672, 16'h5773, 16'h5874};
        check_pairs("t5b");
        check_stall("t5b");

        // Reset mid-frame after two pairs
        qa = '{8'h81, 8'h82, 8'h83, 8'h84};
        qb = '{8'h91, 8'h92, 8'h93, 8'h94};
        begin_frame();
        n = 0;
        while (got.size() < 2 && n < 50) begin
            step();
            n++;
        end
        check_eq("t6_two_pairs", 32'(got.size()), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_rst_pixels", 32'({pixelA, pixelB, userInputA}), 32'd0);
        check_eq("t6_rst_ctrl", 32'({opcode, issue_valid, busy, frame_done, a_ready, b_ready}), 32'd0);
        qa.delete();
        qb.delete();
        a_valid = 1'b0;
        b_valid = 1'b0;
        occ_a = 0;
        occ_b = 0;
        last_a = 1'b0;
        last_b = 1'b0;
        exp_op = '0;
        exp_user = '0;
        @(negedge clk);
        rst = 1'b1;
        step();
        step();
        step();
        check_eq("t6_idle_ready", 32'({a_ready, b_ready}), 32'd0);
        check_eq("t6_no_issue_no_done", 32'({8'(got.size()), 8'(done_cnt)}), 32'h0200);

        // Fresh frame with config loaded together with start
        cfg_opcode = 4'h5;
        cfg_user   = 8'h22;
        cfg_load   = 1'b1;
        exp_op     = 4'h5;
        exp_user   = 8'h22;
        qa = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        qb = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        begin_frame();
        cfg_load = 1'b0;
        run_until_done("t6b");
        exp_q = '{16'hA1B1, 16'hA2B2, 16'hA3B3, 16'hA4B4};
        check_pairs("t6b");
        check_eq("t6b_cfg", 32'({opcode, userInputA}), 32'h522);
        check_eq("t6b_cfg_stable", 32'(cfg_bad), 32'd0);
        check_stall("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
